// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - registered load formatter: byte/half/word extract, extend, optional two-beat merge
// Optional feature macro: LS_UNALIGNED_EN (word-crossing loads merged from two memory beats).
module load_align_unit #(
   parameter int DATA_W = 32,
   parameter int OFF_W  = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [OFF_W-1:0]  req_off,
   output logic              mem_req,
   output logic              mem_second,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BEAT0 = 2'd1;
   localparam logic [1:0] S_BEAT1 = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [OFF_W:0] BYTES = (OFF_W+1)'(DATA_W/8);

   function automatic logic [OFF_W:0] nb_of(input logic [1:0] sz);
      case (sz)
         2'b01:   nb_of = (OFF_W+1)'(2);
         2'b10:   nb_of = (OFF_W+1)'(1);
         default: nb_of = BYTES;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] fmt(input logic [2*DATA_W-1:0] pair,
                                             input logic [1:0] sz, input logic sgn,
                                             input logic [OFF_W-1:0] off);
      logic [2*DATA_W-1:0] sh;
      sh = pair >> {off, 3'b000};
      case (sz)
         2'b10:   fmt = {{(DATA_W-8){sgn & sh[7]}}, sh[7:0]};
         2'b01:   fmt = {{(DATA_W-16){sgn & sh[15]}}, sh[15:0]};
         default: fmt = sh[DATA_W-1:0];
      endcase
   endfunction

   logic [1:0]        state_q, state_d;
   logic              first_q, first_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_q, err_d;
   logic              req_err;
`ifdef LS_UNALIGNED_EN
   logic [DATA_W-1:0] lo_q, lo_d;
   logic              cross;

   assign cross   = ({1'b0, off_q} + nb_of(size_q)) > BYTES;
   assign req_err = (req_size == 2'b11);
`else
   logic [OFF_W:0] req_nb;

   assign req_nb  = nb_of(req_size);
   assign req_err = (req_size == 2'b11) | (({1'b0, req_off} & (req_nb - 1'b1)) != '0);
`endif

   always_comb begin
      state_d  = state_q;
      first_d  = first_q;
      size_d   = size_q;
      signed_d = signed_q;
      off_d    = off_q;
      data_d   = data_q;
      err_d    = err_q;
`ifdef LS_UNALIGNED_EN
      lo_d     = lo_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               size_d   = req_size;
               signed_d = req_signed;
               off_d    = req_off;
               if (req_err) begin
                  err_d   = 1'b1;
                  data_d  = '0;
                  state_d = S_DONE;
               end else begin
                  first_d = 1'b1;
                  state_d = S_BEAT0;
               end
            end
         end
         // The mem_req cycle of each beat never samples mem_valid.
         S_BEAT0: begin
            if (first_q) begin
               first_d = 1'b0;
            end else if (mem_valid) begin
`ifdef LS_UNALIGNED_EN
               lo_d = mem_rdata;
               if (cross) begin
                  first_d = 1'b1;
                  state_d = S_BEAT1;
               end else begin
`else
               begin
`endif
                  data_d  = fmt({{DATA_W{1'b0}}, mem_rdata}, size_q, signed_q, off_q);
                  state_d = S_DONE;
               end
            end
         end
`ifdef LS_UNALIGNED_EN
         S_BEAT1: begin
            if (first_q) begin
               first_d = 1'b0;
            end else if (mem_valid) begin
               data_d  = fmt({mem_rdata, lo_q}, size_q, signed_q, off_q);
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            if (out_ready) begin
               data_d  = '0;
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         first_q  <= 1'b0;
         size_q   <= '0;
         signed_q <= 1'b0;
         off_q    <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
`ifdef LS_UNALIGNED_EN
         lo_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         first_q  <= first_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         off_q    <= off_d;
         data_q   <= data_d;
         err_q    <= err_d;
`ifdef LS_UNALIGNED_EN
         lo_q     <= lo_d;
`endif
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_data  = data_q;
   assign out_err   = err_q;
   assign mem_req   = first_q & ((state_q == S_BEAT0) | (state_q == S_BEAT1));
`ifdef LS_UNALIGNED_EN
   assign mem_second = first_q & (state_q == S_BEAT1);
`else
   assign mem_second = 1'b0;
`endif

endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - scoreboard bench for load_align_unit (honours LS_UNALIGNED_EN)
module tb_load_align_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_signed;
   logic [1:0]  req_size, req_off;
   logic        mem_req, mem_second, mem_valid;
   logic [31:0] mem_rdata;
   logic        out_valid, out_ready, out_err;
   logic [31:0] out_data;

   int          vecs = 0;
   int          errs = 0;
   int          mreq_cnt = 0;
   int          msec_cnt = 0;
   int          mem_lat = 0;
   logic [31:0] mem_w0 = '0;
   logic [31:0] mem_w1 = '0;
   logic [32:0] sb_q[$];

   always #5 clk = ~clk;

   load_align_unit #(.DATA_W(32), .OFF_W(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_size(req_size),
      .req_signed(req_signed), .req_off(req_off),
      .mem_req(mem_req), .mem_second(mem_second), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin : monitor
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("out_err", 32'(out_err), 32'(e[32]));
               chk("out_data", out_data, e[31:0]);
            end
         end
      end
   end

   initial begin : mem_counter
      forever begin
         @(negedge clk);
         if (mem_req) begin
            mreq_cnt++;
            if (mem_second) msec_cnt++;
         end
      end
   end

   initial begin : mem_model
      logic sec;
      mem_valid = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            sec = mem_second;
            @(posedge clk); #1;
            repeat (mem_lat) begin @(posedge clk); #1; end
            mem_valid = 1'b1;
            mem_rdata = sec ? mem_w1 : mem_w0;
            @(posedge clk); #1;
            mem_valid = 1'b0;
            mem_rdata = '0;
         end
      end
   end

   task automatic run_load(input logic [1:0] sz, input logic sg, input logic [1:0] off,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic e_err, input logic [31:0] e_data,
                           input int e_lat, input int e_mreq, input int e_msec, input int hold);
      int n, m0, s0;
      mem_w0 = w0;
      mem_w1 = w1;
      m0 = mreq_cnt;
      s0 = msec_cnt;
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      sb_q.push_back({e_err, e_data});
      req_valid = 1'b1; req_size = sz; req_signed = sg; req_off = off;
      @(posedge clk); #1;
      req_valid = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_off = 2'b00;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, e_lat);
      repeat (hold) begin
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_data", out_data, e_data);
         chk("hold_req_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("back_idle", {30'd0, req_ready, out_valid}, 32'b10);
      chk("mem_req_count", mreq_cnt - m0, e_mreq);
      chk("mem_second_count", msec_cnt - s0, e_msec);
   endtask

   initial begin : stim
      int m0;
      reset_n = 1'b0;
      req_valid = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_off = 2'b00;
      out_ready = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("reset_ctl", {27'd0, req_ready, out_valid, mem_req, mem_second, out_err}, 32'b10000);
      chk("reset_data", out_data, 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      run_load(2'b10, 1'b1, 2'd3, 32'h80123456, 32'h0, 1'b0, 32'hFFFFFF80, 2, 1, 0, 0);
      run_load(2'b10, 1'b0, 2'd3, 32'h80123456, 32'h0, 1'b0, 32'h00000080, 2, 1, 0, 0);
      run_load(2'b10, 1'b1, 2'd1, 32'h0000FF00, 32'h0, 1'b0, 32'hFFFFFFFF, 2, 1, 0, 0);
      run_load(2'b01, 1'b0, 2'd2, 32'hBEEF1234, 32'h0, 1'b0, 32'h0000BEEF, 2, 1, 0, 0);
      run_load(2'b01, 1'b1, 2'd2, 32'hBEEF1234, 32'h0, 1'b0, 32'hFFFFBEEF, 2, 1, 0, 0);
      run_load(2'b00, 1'b0, 2'd0, 32'hDEADBEEF, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1, 0, 3);
`ifdef LS_UNALIGNED_EN
      run_load(2'b00, 1'b0, 2'd1, 32'h44332211, 32'h88776655, 1'b0, 32'h55443322, 4, 2, 1, 0);
      run_load(2'b01, 1'b1, 2'd3, 32'h44332211, 32'h887766F5, 1'b0, 32'hFFFFF544, 4, 2, 1, 0);
      run_load(2'b01, 1'b0, 2'd1, 32'h44332211, 32'h0, 1'b0, 32'h00003322, 2, 1, 0, 0);
`else
      run_load(2'b00, 1'b0, 2'd1, 32'h44332211, 32'h88776655, 1'b1, 32'h0, 0, 0, 0, 0);
      run_load(2'b01, 1'b1, 2'd3, 32'h44332211, 32'h887766F5, 1'b1, 32'h0, 0, 0, 0, 0);
      run_load(2'b01, 1'b0, 2'd1, 32'h44332211, 32'h0, 1'b1, 32'h0, 0, 0, 0, 0);
`endif
      run_load(2'b11, 1'b0, 2'd0, 32'h12345678, 32'h0, 1'b1, 32'h0, 0, 0, 0, 1);

      // Reset while BEAT0 waits; the delayed memory reply then arrives in IDLE.
      mem_lat = 3;
      mem_w0 = 32'h11111111;
      req_valid = 1'b1; req_size = 2'b00; req_off = 2'd0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      chk("midop_reset_ctl", {27'd0, req_ready, out_valid, mem_req, mem_second, out_err}, 32'b10000);
      chk("midop_reset_data", out_data, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      m0 = mreq_cnt;
      repeat (8) begin
         @(posedge clk); #1;
         chk("stray_ignored", {30'd0, req_ready, out_valid}, 32'b10);
      end
      chk("stray_no_mem_req", mreq_cnt - m0, 0);
      mem_lat = 0;
      run_load(2'b10, 1'b0, 2'd0, 32'h000000AB, 32'h0, 1'b0, 32'h000000AB, 2, 1, 0, 0);

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
